// File: rtl/pa_pkg.sv
// Shared encodings for the PE-array memory interface: accelerator phase codes and controller states.
package pa_pkg;
  localparam logic [1:0] PA_WLOAD = 2'b01;
  localparam logic [1:0] PA_DLOAD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WLOAD,
    ST_DLOAD,
    ST_DRAIN,
    ST_FIN
  } pa_state_e;
endpackage

// File: rtl/pa_mem_if_if.sv
// Host, source SRAM, accelerator memIF and destination SRAM signals of pa_mem_if.
// The master modport is the memory-side controller; slave is its environment.
interface pa_mem_if_if #(
  parameter int AW = 16,
  parameter int DW = 32
);
  logic          start;
  logic [AW-1:0] w_base, d_base, r_base;
  logic [AW-1:0] w_words, d_words, r_words;
  logic          src_en;
  logic [AW-1:0] src_addr;
  logic [DW-1:0] src_rdata;
  logic [DW-1:0] data;
  logic          read_rdy;
  logic          read_acq;
  logic [1:0]    pa_state;
  logic          write_rdy;
  logic          write_acq;
  logic [DW-1:0] result_in;
  logic          dst_we;
  logic [AW-1:0] dst_addr;
  logic [DW-1:0] dst_wdata;
  logic          busy;
  logic          done;

  modport master (
    input  start, w_base, d_base, r_base, w_words, d_words, r_words,
    input  src_rdata, read_acq, pa_state, write_rdy, result_in,
    output src_en, src_addr, data, read_rdy, write_acq,
    output dst_we, dst_addr, dst_wdata, busy, done
  );

  modport slave (
    output start, w_base, d_base, r_base, w_words, d_words, r_words,
    output src_rdata, read_acq, pa_state, write_rdy, result_in,
    input  src_en, src_addr, data, read_rdy, write_acq,
    input  dst_we, dst_addr, dst_wdata, busy, done
  );
endinterface

// File: rtl/pa_prefetch_fifo.sv
// Prefetch FIFO for source read data; registered head pointer, same-cycle push+pop keeps count.
// No full/empty protection: the caller only pushes when a slot was reserved at issue time.
module pa_prefetch_fifo #(
  parameter int DW = 32,
  parameter int FD = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 push_i,
  input  logic [DW-1:0]        push_dat_i,
  input  logic                 pop_i,
  output logic [DW-1:0]        head_o,
  output logic [$clog2(FD):0]  count_o,
  output logic                 empty_o
);
  localparam int PW = $clog2(FD);

  logic [DW-1:0] mem_q [FD];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [PW:0]   count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{PW{1'b0}}, push_i} - {{PW{1'b0}}, pop_i};
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
endmodule

// File: rtl/pa_mem_if.sv
// Streams weight then activation words from a source SRAM to the PE array and writes its results
// to a destination SRAM; first word 3 cycles after start, 1 word/cycle, stalls on read_acq/pa_state.
module pa_mem_if
  import pa_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 32,
  parameter int FD = 4
) (
  input logic         clk,
  input logic         rst,
  pa_mem_if_if.master bus
);
  localparam int CW = $clog2(FD) + 1;

  pa_state_e     state_q, state_d;
  logic [AW-1:0] w_base_q, d_base_q, r_base_q, w_words_q, d_words_q, r_words_q;
  logic [AW-1:0] issued_q, acked_q, rcount_q;
  logic          in_flight_q, ovf_q;
  logic          dst_we_q;
  logic [AW-1:0] dst_addr_q;
  logic [DW-1:0] dst_wdata_q, data_q;

  logic          load, read_rdy, pop, issue, last, busy, wr_xfer, launch;
  logic [AW-1:0] phase_cnt, phase_base;
  logic [1:0]    phase_code;
  logic [AW:0]   acked_nx;
  logic [CW:0]   occ_lhs, occ_rhs;
  logic [DW-1:0] fifo_head;
  logic [CW-1:0] fifo_cnt;
  logic          fifo_empty;

  assign load       = (state_q == ST_WLOAD) || (state_q == ST_DLOAD);
  assign phase_cnt  = (state_q == ST_DLOAD) ? d_words_q : w_words_q;
  assign phase_base = (state_q == ST_DLOAD) ? d_base_q : w_base_q;
  assign phase_code = (state_q == ST_DLOAD) ? PA_DLOAD : PA_WLOAD;
  assign read_rdy   = load && !fifo_empty && (bus.pa_state == phase_code);
  assign pop        = read_rdy && bus.read_acq;
  assign acked_nx   = {1'b0, acked_q} + {{AW{1'b0}}, pop};
  assign last       = load && (acked_nx == {1'b0, phase_cnt});

  // A slot is reserved at issue time, so the response arriving next cycle always fits.
  assign occ_lhs = {1'b0, fifo_cnt} + {{CW{1'b0}}, in_flight_q};
  assign occ_rhs = (CW+1)'(FD) + {{CW{1'b0}}, pop};
  assign issue   = load && (occ_lhs < occ_rhs) && (issued_q < phase_cnt);

  assign busy    = (state_q == ST_WLOAD) || (state_q == ST_DLOAD) || (state_q == ST_DRAIN);
  assign wr_xfer = bus.write_rdy && busy;
  assign launch  = (state_q == ST_IDLE) && bus.start;

  pa_prefetch_fifo #(.DW(DW), .FD(FD)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (last),
    .push_i     (in_flight_q),
    .push_dat_i (bus.src_rdata),
    .pop_i      (pop),
    .head_o     (fifo_head),
    .count_o    (fifo_cnt),
    .empty_o    (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.start) state_d = ST_WLOAD;
      ST_WLOAD: if (last) state_d = ST_DLOAD;
      ST_DLOAD: if (last) state_d = (rcount_q == r_words_q) ? ST_FIN : ST_DRAIN;
      ST_DRAIN: if (rcount_q == r_words_q) state_d = ST_FIN;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      w_base_q    <= '0;
      d_base_q    <= '0;
      r_base_q    <= '0;
      w_words_q   <= '0;
      d_words_q   <= '0;
      r_words_q   <= '0;
      issued_q    <= '0;
      acked_q     <= '0;
      rcount_q    <= '0;
      in_flight_q <= 1'b0;
      ovf_q       <= 1'b0;
      dst_we_q    <= 1'b0;
      dst_addr_q  <= '0;
      dst_wdata_q <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      in_flight_q <= issue;
      dst_we_q    <= 1'b0;
      if (read_rdy) data_q <= fifo_head;

      if (launch) begin
        w_base_q  <= bus.w_base;
        d_base_q  <= bus.d_base;
        r_base_q  <= bus.r_base;
        w_words_q <= bus.w_words;
        d_words_q <= bus.d_words;
        r_words_q <= bus.r_words;
        issued_q  <= '0;
        acked_q   <= '0;
        rcount_q  <= '0;
        ovf_q     <= 1'b0;
      end else begin
        if (last) begin
          issued_q <= '0;
          acked_q  <= '0;
        end else begin
          if (issue) issued_q <= issued_q + 1'b1;
          if (pop)   acked_q  <= acked_q + 1'b1;
        end
        // Results beyond r_words are still handshaken but never written.
        if (wr_xfer && (rcount_q != r_words_q)) begin
          dst_we_q    <= 1'b1;
          dst_addr_q  <= r_base_q + rcount_q;
          dst_wdata_q <= bus.result_in;
          rcount_q    <= rcount_q + 1'b1;
        end
        ovf_q <= ovf_q || (wr_xfer && (rcount_q == r_words_q));
      end
    end
  end

  assign bus.src_en    = issue;
  assign bus.src_addr  = phase_base + issued_q;
  assign bus.read_rdy  = read_rdy;
  assign bus.data      = read_rdy ? fifo_head : data_q;
  assign bus.write_acq = busy;
  assign bus.dst_we    = dst_we_q;
  assign bus.dst_addr  = dst_addr_q;
  assign bus.dst_wdata = dst_wdata_q;
  assign bus.busy      = busy;
  assign bus.done      = (state_q == ST_FIN);
endmodule

// File: tb/tb_pa_mem_if.sv
// Randomised bench for pa_mem_if against a transaction-level model of the job (expected word stream,
// read addresses, destination writes and done timing derived from the job parameters).
module tb_pa_mem_if;
  import pa_pkg::*;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int FD = 4;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] dat;
    int            cyc;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  pa_mem_if_if #(.AW(AW), .DW(DW)) bus ();

  pa_mem_if #(.AW(AW), .DW(DW), .FD(FD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [DW-1:0] src_word(input logic [AW-1:0] a);
    return {a ^ 16'h5A3C, ~a};
  endfunction

  // Source SRAM: one-cycle read latency.
  always @(posedge clk) begin
    if (bus.src_en) bus.src_rdata <= src_word(bus.src_addr);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic run_job(input logic [AW-1:0] wb, input logic [AW-1:0] wn,
                         input logic [AW-1:0] db, input logic [AW-1:0] dn,
                         input logic [AW-1:0] rb, input logic [AW-1:0] rn,
                         input int acq_pct, input int stall, input int extra,
                         input int abort_at, input bit directed);
    logic [DW-1:0] exp_words[$];
    logic [AW-1:0] exp_addr[$];
    wr_t           exp_wr[$];
    wr_t           w;
    logic [DW-1:0] prev_data = '0;
    bit            prev_hold = 1'b0;
    bit            ph2 = (wn == 0);
    bit            fin = 1'b0;
    int cyc = 0, accepted = 0, issued = 0, sent = 0, dst_cnt = 0;
    int done_cnt = 0, done_cyc = -1, last_acc = -1, last_we = -1, first_rdy = -1;
    int max_out = 0, stab_err = 0, rdy_bad = 0, w_last = -1, d_first = -1, d_last = -1;
    int exp_done;

    for (int i = 0; i < int'(wn); i++) begin
      exp_addr.push_back(wb + AW'(i));
      exp_words.push_back(src_word(wb + AW'(i)));
    end
    for (int i = 0; i < int'(dn); i++) begin
      exp_addr.push_back(db + AW'(i));
      exp_words.push_back(src_word(db + AW'(i)));
    end

    @(negedge clk);
    bus.start   = 1'b1;
    bus.w_base  = wb;  bus.w_words = wn;
    bus.d_base  = db;  bus.d_words = dn;
    bus.r_base  = rb;  bus.r_words = rn;

    while (!fin && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      bus.start    = 1'b0;
      bus.pa_state = (cyc <= stall) ? 2'b00 : (ph2 ? PA_DLOAD : PA_WLOAD);
      bus.read_acq = ($urandom_range(99) < acq_pct);
      if (done_cyc < 0 && sent < int'(rn) + extra && $urandom_range(1) == 1) begin
        bus.write_rdy = 1'b1;
        bus.result_in = $urandom;
      end else begin
        bus.write_rdy = 1'b0;
      end
      #1;
      if (cyc == abort_at) begin
        chk("abort_in_flight", 64'(issued - accepted), 64'd2);
        rst = 1'b1;
        #1;
        chk("abort_flags", {bus.src_en, bus.read_rdy, bus.write_acq, bus.dst_we, bus.busy, bus.done}, 0);
        chk("abort_addrs", {bus.src_addr, bus.dst_addr}, 0);
        chk("abort_data", {bus.data, bus.dst_wdata}, 0);
        fin = 1'b1;
      end else begin
        if (cyc == 1) chk("busy_c1", bus.busy, 1);
        if (cyc == 1 && directed) chk("src_en_c1", bus.src_en, 64'(wn != 0));
        if (prev_hold && (!bus.read_rdy || bus.data !== prev_data)) stab_err++;
        prev_hold = bus.read_rdy && !bus.read_acq;
        prev_data = bus.data;
        if (bus.pa_state == 2'b00 && bus.read_rdy) rdy_bad++;
        if (bus.read_rdy && first_rdy < 0) first_rdy = cyc;
        if (bus.src_en) begin
          issued++;
          if (exp_addr.size() > 0) chk("src_addr", bus.src_addr, exp_addr.pop_front());
        end
        if (bus.read_rdy && bus.read_acq) begin
          accepted++;
          if (exp_words.size() > 0) chk("word", bus.data, exp_words.pop_front());
          if (accepted <= int'(wn)) w_last = cyc;
          else begin
            if (d_first < 0) d_first = cyc;
            d_last = cyc;
          end
          if (accepted == int'(wn)) ph2 = 1'b1;
          last_acc = cyc;
        end
        if (issued - accepted > max_out) max_out = issued - accepted;
        if (bus.dst_we) begin
          dst_cnt++;
          last_we = cyc;
          if (exp_wr.size() > 0) begin
            w = exp_wr.pop_front();
            chk("dst_addr", bus.dst_addr, w.addr);
            chk("dst_wdata", bus.dst_wdata, w.dat);
            chk("dst_latency", 64'(cyc - w.cyc), 64'd1);
          end
        end
        if (bus.write_rdy && bus.write_acq) begin
          if (sent < int'(rn)) exp_wr.push_back('{addr: rb + AW'(sent), dat: bus.result_in, cyc: cyc});
          sent++;
        end
        if (bus.done) begin
          done_cnt++;
          if (done_cyc < 0) begin
            done_cyc = cyc;
            chk("busy_at_done", bus.busy, 0);
          end
        end
        if (done_cyc >= 0 && cyc >= done_cyc + 3) fin = 1'b1;
      end
    end
    bus.write_rdy = 1'b0;
    bus.read_acq  = 1'b0;

    if (abort_at == 0) begin
      chk("job_completed", 64'(done_cyc >= 0), 1);
      exp_done = 3;
      if (last_acc + 1 > exp_done) exp_done = last_acc + 1;
      if (last_we + 1 > exp_done) exp_done = last_we + 1;
      chk("done_count", 64'(done_cnt), 1);
      chk("done_cycle", 64'(done_cyc), 64'(exp_done));
      chk("accepted", 64'(accepted), 64'(int'(wn) + int'(dn)));
      chk("issued", 64'(issued), 64'(int'(wn) + int'(dn)));
      chk("dst_count", 64'(dst_cnt), 64'((sent < int'(rn)) ? sent : int'(rn)));
      chk("outstanding_le_fd", 64'(max_out <= FD), 1);
      chk("data_stable", 64'(stab_err), 0);
      chk("rdy_gated", 64'(rdy_bad), 0);
      chk("ovf", dut.ovf_q, 64'(sent > int'(rn)));
      if (directed) begin
        chk("first_rdy", 64'(first_rdy), 3);
        chk("w_rate", 64'(w_last - first_rdy), 64'(int'(wn) - 1));
        chk("d_rate", 64'(d_last - d_first), 64'(int'(dn) - 1));
      end
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.w_base    = '0; bus.d_base  = '0; bus.r_base  = '0;
    bus.w_words   = '0; bus.d_words = '0; bus.r_words = '0;
    bus.read_acq  = 1'b0;
    bus.pa_state  = 2'b00;
    bus.write_rdy = 1'b0;
    bus.result_in = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_flags", {bus.src_en, bus.read_rdy, bus.write_acq, bus.dst_we, bus.busy, bus.done}, 0);
    chk("reset_busses", {bus.src_addr, bus.dst_addr, bus.data, bus.dst_wdata}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back streaming with an always-ready accelerator.
    run_job(16'h0100, 16'd4, 16'h0200, 16'd8, 16'h0800, 16'd4, 100, 0, 0, 0, 1'b1);
    // Random acceptance, random results, overflowing result counts.
    for (int j = 0; j < 6; j++)
      run_job(AW'($urandom), AW'($urandom_range(6)), AW'($urandom), AW'($urandom_range(9, 1)),
              AW'($urandom), AW'($urandom_range(5)), 50, 0, int'($urandom_range(2)), 0, 1'b0);
    // Accelerator not in a load phase for the first 10 cycles.
    run_job(16'h1000, 16'd8, 16'h2000, 16'd3, 16'h3000, 16'd2, 100, 10, 0, 0, 1'b0);
    // Empty job.
    run_job(16'h0040, 16'd0, 16'h0050, 16'd0, 16'h0060, 16'd0, 100, 0, 0, 0, 1'b0);
    // Source and destination address wrap.
    run_job(16'h4000, 16'd2, 16'hFFFE, 16'd4, 16'hFFFF, 16'd3, 100, 0, 1, 0, 1'b0);
    // Reset in DLOAD with two reads outstanding, then a clean rerun.
    run_job(16'h0300, 16'd4, 16'h0400, 16'd8, 16'h0500, 16'd4, 100, 0, 0, 9, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    run_job(16'h0300, 16'd4, 16'h0400, 16'd8, 16'h0500, 16'd4, 100, 0, 0, 0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
